// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS sequencer (master) and the datapath (slave).
// Signal suffixes are relative to the sequencer.
interface multicycle_control_fsm_if;
   logic [5:0] op_in;
   logic [5:0] func_in;
   logic       zero_in;
   logic       mem_ready_in;
   logic       pc_write_out;
   logic       pc_write_cond_out;
   logic       iord_out;
   logic       mem_read_out;
   logic       mem_write_out;
   logic       ir_write_out;
   logic       mem_to_reg_out;
   logic       reg_dst_out;
   logic       reg_write_out;
   logic       alu_src_a_out;
   logic [1:0] alu_src_b_out;
   logic [1:0] alu_op_out;
   logic [1:0] pc_src_out;
   logic       illegal_op_out;
   logic       mem_err_out;
   logic [3:0] state_out;

   modport master (
      input  op_in, func_in, zero_in, mem_ready_in,
      output pc_write_out, pc_write_cond_out, iord_out, mem_read_out, mem_write_out,
             ir_write_out, mem_to_reg_out, reg_dst_out, reg_write_out, alu_src_a_out,
             alu_src_b_out, alu_op_out, pc_src_out, illegal_op_out, mem_err_out, state_out
   );

   modport slave (
      output op_in, func_in, zero_in, mem_ready_in,
      input  pc_write_out, pc_write_cond_out, iord_out, mem_read_out, mem_write_out,
             ir_write_out, mem_to_reg_out, reg_dst_out, reg_write_out, alu_src_a_out,
             alu_src_b_out, alu_op_out, pc_src_out, illegal_op_out, mem_err_out, state_out
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: shares one ALU and one memory over 3-5 cycles per
// instruction, waits on memory ready with a timeout, and flags illegal opcodes.
module multicycle_control_fsm #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   multicycle_control_fsm_if.master bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6, ALUWB  = 4'd7,
      ADDIEX = 4'd8,  ADDIWB = 4'd9,  BRANCH = 4'd10, JUMP  = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_o;
   logic             illegal_q, illegal_d;
   logic             mem_err_q, mem_err_d;
   logic             wait_state, timeout, func_ok, fetch_hit;
   logic             unused_zero;

   // Datapath muxes/enables for a given state; FETCH's IR/PC load is added on ready
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:          begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         DECODE:         c.alu_src_b = 2'b11;
         MEMADR, ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         EXEC:           begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         MEMRD:          begin c.mem_read = 1'b1; c.iord = 1'b1; end
         MEMWR:          begin c.mem_write = 1'b1; c.iord = 1'b1; end
         MEMWB:          begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         ALUWB:          begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         ADDIWB:         c.reg_write = 1'b1;
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_src        = 2'b01;
            c.pc_write_cond = 1'b1;
         end
         JUMP:           begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
         default:        c = '0;
      endcase
      return c;
   endfunction

   // Branch condition is resolved in the datapath through pc_write_cond
   assign unused_zero = bus.zero_in;

   assign func_ok    = bus.func_in inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   assign timeout    = wait_state && !bus.mem_ready_in && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next state, wait counter and pulse requests
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      illegal_d = 1'b0;
      mem_err_d = 1'b0;
      if (wait_state && !bus.mem_ready_in && !timeout)
         cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
         FETCH:  if (bus.mem_ready_in) state_d = DECODE;
         DECODE: begin
            case (bus.op_in)
               OP_RTYPE: begin
                  if (func_ok) state_d = EXEC;
                  else begin
                     state_d   = FETCH;
                     illegal_d = 1'b1;
                  end
               end
               OP_LW, OP_SW: state_d = MEMADR;
               OP_ADDI:      state_d = ADDIEX;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: state_d = (bus.op_in == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (bus.mem_ready_in) state_d = MEMWB;
         MEMWR:  if (bus.mem_ready_in) state_d = FETCH;
         EXEC:   state_d = ALUWB;
         ADDIEX: state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
      if (timeout) begin
         state_d   = FETCH;
         mem_err_d = 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with state_q
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         ctrl_q    <= decode(FETCH);
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= decode(state_d);
         illegal_q <= illegal_d;
         mem_err_q <= mem_err_d;
      end
   end

   // IR/PC load completes in the same cycle memory returns the instruction
   assign fetch_hit = (state_q == FETCH) && bus.mem_ready_in;

   always_comb begin
      ctrl_o          = ctrl_q;
      ctrl_o.ir_write = fetch_hit;
      ctrl_o.pc_write = ctrl_q.pc_write | fetch_hit;
      if (rst_in)
         ctrl_o = '0;
   end

   assign bus.pc_write_out      = ctrl_o.pc_write;
   assign bus.pc_write_cond_out = ctrl_o.pc_write_cond;
   assign bus.iord_out          = ctrl_o.iord;
   assign bus.mem_read_out      = ctrl_o.mem_read;
   assign bus.mem_write_out     = ctrl_o.mem_write;
   assign bus.ir_write_out      = ctrl_o.ir_write;
   assign bus.mem_to_reg_out    = ctrl_o.mem_to_reg;
   assign bus.reg_dst_out       = ctrl_o.reg_dst;
   assign bus.reg_write_out     = ctrl_o.reg_write;
   assign bus.alu_src_a_out     = ctrl_o.alu_src_a;
   assign bus.alu_src_b_out     = ctrl_o.alu_src_b;
   assign bus.alu_op_out        = ctrl_o.alu_op;
   assign bus.pc_src_out        = ctrl_o.pc_src;
   assign bus.illegal_op_out    = illegal_q;
   assign bus.mem_err_out       = mem_err_q;
   assign bus.state_out         = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instruction-level model pushes per-cycle
// expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
   localparam int unsigned TIMEOUT = 16;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
   localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
   localparam logic [3:0] S_ADDIEX = 4'd8, S_ADDIWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctl_t;

   typedef struct packed {
      logic [3:0]  st;
      ctl_t        c;
      logic        ill;
      logic        err;
      logic [15:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   instr_no = 0;
   bit   pend_ill, pend_err;
   exp_t sb[$];
   ctl_t act;
   logic [5:0] valid_fn [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

   multicycle_control_fsm_if bus();

   multicycle_control_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   assign act = {bus.pc_write_out, bus.pc_write_cond_out, bus.iord_out, bus.mem_read_out,
                 bus.mem_write_out, bus.ir_write_out, bus.mem_to_reg_out, bus.reg_dst_out,
                 bus.reg_write_out, bus.alu_src_a_out, bus.alu_src_b_out, bus.alu_op_out,
                 bus.pc_src_out};

   // Control table straight from the per-state output list
   function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy);
      ctl_t c;
      c = '0;
      case (st)
         S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         S_EXEC:   begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
         S_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
         S_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
         S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; c.reg_dst = 0; end
         S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
         S_ADDIWB: begin c.reg_write = 1; c.reg_dst = 0; end
         S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write_cond = 1; end
         S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
      bit ok;
      ok = 0;
      if (op == OP_R) begin
         foreach (valid_fn[i]) if (fn == valid_fn[i]) ok = 1;
      end else if (op == OP_LW || op == OP_SW || op == OP_ADDI || op == OP_BEQ || op == OP_J)
         ok = 1;
      return ok;
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   // One clock cycle: drive ready, push the expectation, advance to posedge+1
   task automatic step(input logic [3:0] st, input logic rdy, input bit ill_now, input bit err_now);
      exp_t e;
      bus.mem_ready_in = rdy;
      bus.zero_in      = rbit();
      e.st  = st;
      e.c   = exp_ctl(st, rdy);
      e.ill = pend_ill;
      e.err = pend_err;
      e.tag = 16'(instr_no);
      sb.push_back(e);
      pend_ill = ill_now;
      pend_err = err_now;
      @(posedge clk);
      #1;
   endtask

   // Memory wait: n cycles without ready, then ready; abort on the TIMEOUT-th idle cycle
   task automatic mem_phase(input logic [3:0] st, input int n, output bit timed_out);
      timed_out = 0;
      for (int i = 0; i < n && i < int'(TIMEOUT); i++) begin
         if (i == int'(TIMEOUT) - 1) begin
            step(st, 1'b0, 0, 1);
            timed_out = 1;
            return;
         end
         step(st, 1'b0, 0, 0);
      end
      step(st, 1'b1, 0, 0);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait, input int mwait);
      bit to;
      instr_no++;
      bus.op_in   = op;
      bus.func_in = fn;
      mem_phase(S_FETCH, fwait, to);
      if (to) return;
      if (!is_legal(op, fn)) begin
         step(S_DECODE, rbit(), 1, 0);
         return;
      end
      step(S_DECODE, rbit(), 0, 0);
      case (op)
         OP_R:    begin step(S_EXEC, rbit(), 0, 0); step(S_ALUWB, rbit(), 0, 0); end
         OP_ADDI: begin step(S_ADDIEX, rbit(), 0, 0); step(S_ADDIWB, rbit(), 0, 0); end
         OP_BEQ:  step(S_BRANCH, rbit(), 0, 0);
         OP_J:    step(S_JUMP, rbit(), 0, 0);
         OP_LW: begin
            step(S_MEMADR, rbit(), 0, 0);
            mem_phase(S_MEMRD, mwait, to);
            if (!to) step(S_MEMWB, rbit(), 0, 0);
         end
         default: begin
            step(S_MEMADR, rbit(), 0, 0);
            mem_phase(S_MEMWR, mwait, to);
         end
      endcase
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (bus.state_out !== 4'd0 || act !== '0 || bus.illegal_op_out !== 1'b0 || bus.mem_err_out !== 1'b0) begin
         errors++;
         $display("FAIL %s: got state=%0d ctl=%h ill=%b err=%b, want state=0 ctl=0000 ill=0 err=0",
                  name, bus.state_out, act, bus.illegal_op_out, bus.mem_err_out);
      end
   endtask

   task automatic reset_in_memwr();
      bit to;
      instr_no++;
      bus.op_in   = OP_SW;
      bus.func_in = 6'($urandom);
      mem_phase(S_FETCH, 0, to);
      step(S_DECODE, rbit(), 0, 0);
      step(S_MEMADR, rbit(), 0, 0);
      step(S_MEMWR, 1'b0, 0, 0);
      step(S_MEMWR, 1'b0, 0, 0);
      bus.mem_ready_in = 1'b0;
      checks++;
      if (bus.state_out !== S_MEMWR || bus.mem_write_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_memwr: got state=%0d mem_write=%b, want state=5 mem_write=1",
                  bus.state_out, bus.mem_write_out);
      end
      #2 rst = 1'b1;
      #1 check_reset("reset_async_memwr");
      @(negedge clk);
      check_reset("reset_held");
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (bus.state_out !== e.st || act !== e.c || bus.illegal_op_out !== e.ill || bus.mem_err_out !== e.err) begin
            errors++;
            $display("FAIL cycle_check instr=%0d t=%0t: got st=%0d ctl=%h ill=%b err=%b, want st=%0d ctl=%h ill=%b err=%b",
                     e.tag, $time, bus.state_out, act, bus.illegal_op_out, bus.mem_err_out,
                     e.st, e.c, e.ill, e.err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op, fn;
      int sel, fw, mw;
      rst = 1'b1;
      bus.op_in = '0; bus.func_in = '0; bus.zero_in = 1'b0; bus.mem_ready_in = 1'b0;
      pend_ill = 0; pend_err = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset_state");
      @(posedge clk);
      #1 rst = 1'b0;

      run_instr(OP_R, FN_ADD, 0, 0);
      run_instr(OP_LW, 6'h15, 0, 3);
      run_instr(OP_BEQ, 6'h00, 0, 0);
      run_instr(OP_BEQ, 6'h3f, 1, 0);
      run_instr(6'b111111, 6'h00, 0, 0);
      run_instr(OP_R, 6'b000111, 0, 0);
      run_instr(OP_R, FN_SUB, 16, 0);
      run_instr(OP_R, FN_SUB, 15, 0);
      run_instr(OP_LW, 6'h01, 1, 16);
      run_instr(OP_SW, 6'h02, 0, 16);
      run_instr(OP_SW, 6'h03, 2, 2);
      run_instr(OP_ADDI, 6'h04, 0, 0);
      run_instr(OP_J, 6'h05, 0, 0);
      run_instr(OP_R, FN_AND, 1, 0);
      run_instr(OP_R, FN_OR, 0, 0);
      run_instr(OP_R, FN_SLT, 0, 0);
      reset_in_memwr();
      run_instr(OP_R, FN_ADD, 0, 0);

      for (int k = 0; k < 150; k++) begin
         sel = int'($urandom_range(0, 11));
         fn  = 6'($urandom);
         case (sel)
            0, 1, 2, 3, 4: begin op = OP_R; fn = valid_fn[sel]; end
            5:  begin op = OP_R; while (is_legal(op, fn)) fn = 6'($urandom); end
            6:  op = OP_LW;
            7:  op = OP_SW;
            8:  op = OP_ADDI;
            9:  op = OP_BEQ;
            10: op = OP_J;
            default: begin op = 6'($urandom); while (is_legal(op, fn)) op = 6'($urandom); end
         endcase
         fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 14) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 3));
         run_instr(op, fn, fw, mw);
      end

      step(S_FETCH, 1'b0, 0, 0);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
